riscv: RTL and testbench

RISCV -- requirements
Module: riscv

---
 rtl/riscv_pkg.sv | 102 ++++++++++
 rtl/riscv_imem.sv | 36 +++
 rtl/riscv.sv | 226 ++++++++++++++++++++++
 tb/tb_riscv.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and ALU helpers for the single-cycle RV32I core.
// Opcodes, funct fields, ALU operations and writeback selectors.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_PC4,
        WB_MEM
    } wb_sel_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_exec(
        alu_op_e op,
        logic [31:0] a,
        logic [31:0] b
    );
        logic [31:0] r;
        r = '0;
        case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_SLL:   r = a << b[4:0];
            ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {31'b0, a < b};
            ALU_XOR:   r = a ^ b;
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_imem.sv
// Instruction ROM: combinational word fetch, NOP past the end.
// Contents survive reset; the write port exists for program loading.
import riscv_pkg::*;

module imem #(
    parameter int IMEM_DEPTH = 28
) (
    input  logic        clk,
    input  logic [29:0] addr,
    output logic [31:0] inst,
    input  logic        we,
    input  logic [29:0] waddr,
    input  logic [31:0] wdata
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [29:0] DEPTH = 30'(IMEM_DEPTH);

    logic [31:0] tab_inst [0:IMEM_DEPTH-1];

    // Fetch the addressed word, or a NOP when outside the table
    always_comb begin
        inst = NOP_INSN;
        if (addr < DEPTH) begin
            inst = tab_inst[addr[AW-1:0]];
        end
    end

    // Optional program load; the core ties this port off
    always_ff @(posedge clk) begin
        if (we && waddr < DEPTH) begin
            tab_inst[waddr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/riscv.sv
// Single-cycle RV32I core: fetch, decode, execute, retire each clock.
// Register file and data memory are inline and observed by hierarchy.
import riscv_pkg::*;

module riscv #(
    parameter int IMEM_DEPTH = 28
) (
    input logic clk,
    input logic rst
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] inst;

    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:63];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;

    logic        reg_we;
    logic        mem_we;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        taken;
    logic        imm_ok;
    logic        reg_ok;

    alu_op_e     alu_op;
    wb_sel_e     wb_sel;

    imem #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) imem1 (
        .clk   (clk),
        .addr  (pc[31:2]),
        .inst  (inst),
        .we    (1'b0),
        .waddr (30'd0),
        .wdata (32'd0)
    );

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    // Shift immediates carry funct7; only base/alt patterns are legal
    assign imm_ok = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                    (funct3 == F3_SR)  ? (funct7 == F7_BASE ||
                                          funct7 == F7_ALT) :
                    1'b1;
    assign reg_ok = (funct7 == F7_BASE) ||
                    (funct7 == F7_ALT &&
                     (funct3 == F3_ADD || funct3 == F3_SR));

    // Decode control; unknown encodings leave every enable low
    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        alu_op    = ALU_ADD;
        op_a      = rs1_val;
        op_b      = imm_i;
        wb_sel    = WB_ALU;
        case (opcode)
            OP_LUI: begin
                reg_we = 1'b1;
                op_b   = imm_u;
                alu_op = ALU_PASSB;
            end
            OP_AUIPC: begin
                reg_we = 1'b1;
                op_a   = pc;
                op_b   = imm_u;
            end
            OP_JAL: begin
                reg_we = 1'b1;
                is_jal = 1'b1;
                wb_sel = WB_PC4;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    reg_we  = 1'b1;
                    is_jalr = 1'b1;
                    wb_sel  = WB_PC4;
                end
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    reg_we = 1'b1;
                    wb_sel = WB_MEM;
                end
            end
            OP_STORE: begin
                op_b = imm_s;
                if (funct3 == F3_SW) begin
                    mem_we = 1'b1;
                end
            end
            OP_IMM: begin
                reg_we = imm_ok;
                alu_op = alu_decode(funct3,
                                    funct3 == F3_SR && funct7[5]);
            end
            OP_REG: begin
                reg_we = reg_ok;
                op_b   = rs2_val;
                alu_op = alu_decode(funct3, funct7[5]);
            end
            default: begin
                reg_we = 1'b0;
            end
        endcase
    end

    // Branch condition; reserved funct3 values never branch
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val < rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    assign alu_res   = alu_exec(alu_op, op_a, op_b);
    assign mem_rdata = dmem[alu_res[7:2]];

    // Select the value retired into rd
    always_comb begin
        case (wb_sel)
            WB_PC4:  wb_data = pc_plus4;
            WB_MEM:  wb_data = mem_rdata;
            default: wb_data = alu_res;
        endcase
    end

    // Next PC: jumps, taken branches, otherwise sequential
    always_comb begin
        next_pc = pc_plus4;
        if (is_jal) begin
            next_pc = pc + imm_j;
        end else if (is_jalr) begin
            next_pc = {alu_res[31:1], 1'b0};
        end else if (is_branch && taken) begin
            next_pc = pc + imm_b;
        end
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    // Register file write; x0 stays zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_we && rd != 5'd0) begin
            regs[rd] <= wb_data;
        end
    end

    // Data memory store; address wraps within 64 words
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                dmem[i] <= 32'd0;
            end
        end else if (mem_we) begin
            dmem[alu_res[7:2]] <= rs2_val;
        end
    end

endmodule

// File: tb/tb_riscv.sv
// Bench for the single-cycle core: directed programs plus random
// straight-line/forward-branch programs against an instruction-level model.
module tb_riscv;

    localparam int DEPTH = 28;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_imem [DEPTH];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;

    riscv #(
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] e_i(logic [11:0] imm, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d,
                                        logic [6:0] op);
        return {imm, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] e_r(logic [6:0] f7, logic [4:0] s2,
                                        logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'h33};
    endfunction

    function automatic logic [31:0] e_s(logic [11:0] imm, logic [4:0] s2,
                                        logic [4:0] s1, logic [2:0] f3);
        return {imm[11:5], s2, s1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(logic [12:0] off, logic [4:0] s2,
                                        logic [4:0] s1, logic [2:0] f3);
        return {off[12], off[10:5], s2, s1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] e_u(logic [19:0] imm, logic [4:0] d,
                                        logic [6:0] op);
        return {imm, d, op};
    endfunction

    function automatic logic [31:0] e_j(logic [20:0] off, logic [4:0] d);
        return {off[20], off[10:1], off[11], off[19:12], d, 7'h6f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int idx, input logic [31:0] w);
        dut.imem1.tab_inst[idx] = w;
        m_imem[idx] = w;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < DEPTH; i++) ld(i, 32'h0000_0013);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_dmem[i] = 32'd0;
    endtask

    // Instruction-set model: one architectural instruction per call
    task automatic iss_step();
        logic [31:0] ins, a, b, ii, is, ib, iu, ij, res, npc, ea;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  d;
        logic [4:0]  sh;
        bit          wr, t;
        int          widx;
        widx = int'(m_pc[31:2]);
        ins  = (m_pc[31:2] < 30'(DEPTH)) ? m_imem[widx] : 32'h0000_0013;
        op = ins[6:0];
        d  = ins[11:7];
        f3 = ins[14:12];
        f7 = ins[31:25];
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'h000};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = m_pc + 32'd4;
        wr  = 1'b0;
        res = 32'd0;
        t   = 1'b0;
        case (op)
            7'h37: begin wr = 1'b1; res = iu; end
            7'h17: begin wr = 1'b1; res = m_pc + iu; end
            7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1;
                res = m_pc + 32'd4;
                npc = (a + ii) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: t = 1'b0;
                endcase
                if (t) npc = m_pc + ib;
            end
            7'h03: if (f3 == 3'd2) begin
                ea = a + ii;
                wr = 1'b1;
                res = m_dmem[ea[7:2]];
            end
            7'h23: if (f3 == 3'd2) begin
                ea = a + is;
                m_dmem[ea[7:2]] = b;
            end
            7'h13: begin
                sh = ii[4:0];
                wr = 1'b1;
                case (f3)
                    3'd0: res = a + ii;
                    3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    3'd1: if (f7 == 7'h00) res = a << sh; else wr = 1'b0;
                    default: begin
                        if (f7 == 7'h00) res = a >> sh;
                        else if (f7 == 7'h20) res = $signed(a) >>> sh;
                        else wr = 1'b0;
                    end
                endcase
            end
            7'h33: begin
                sh = b[4:0];
                wr = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: res = a + b;
                        3'd1: res = a << sh;
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = a >> sh;
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    res = a - b;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    res = $signed(a) >>> sh;
                end else begin
                    wr = 1'b0;
                end
            end
            default: wr = 1'b0;
        endcase
        if (wr && d != 5'd0) m_regs[d] = res;
        m_pc = npc;
    endtask

    function automatic logic [6:0] rnd_f7();
        int k;
        k = $urandom_range(0, 4);
        if (k < 2) return 7'h00;
        if (k < 4) return 7'h20;
        return 7'($urandom);
    endfunction

    function automatic logic [31:0] rnd_insn();
        logic [4:0]  d, s1, s2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          k;
        d   = 5'($urandom_range(0, 7));
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        k   = $urandom_range(0, 10);
        case (k)
            0, 1, 2: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = rnd_f7();
                if (f3 == 3'd1 && imm[11:5] == 7'h20) imm[11:5] = 7'h00;
                return e_i(imm, s1, f3, d, 7'h13);
            end
            3, 4: return e_r(rnd_f7(), s2, s1, f3, d);
            5: return e_u(20'($urandom), d,
                          ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17);
            6: return e_s(imm, s2, s1,
                          ($urandom_range(0, 3) == 0) ? f3 : 3'd2);
            7: return e_i(imm, s1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2,
                          d, 7'h03);
            8: return e_b(13'($urandom_range(1, 4) * 4), s2, s1, f3);
            9: return e_j(21'($urandom_range(1, 4) * 4), d);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("reset pc", dut.pc, 32'd0);
        chk("reset x5", dut.regs[5], 32'd0);
        chk("reset dmem3", dut.dmem[3], 32'd0);

        // ADDI/ADDI/ADD
        clear_imem();
        ld(0, e_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        ld(1, e_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13));
        ld(2, e_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        do_reset();
        repeat (3) tick();
        chk("add x1", dut.regs[1], 32'd5);
        chk("add x2", dut.regs[2], 32'hFFFF_FFFD);
        chk("add x3", dut.regs[3], 32'd2);
        chk("add pc", dut.pc, 32'h0000_000C);

        // Reset mid-run, then re-execute from word 0
        rst = 1'b0;
        tick();
        chk("rerst pc", dut.pc, 32'd0);
        chk("rerst x1", dut.regs[1], 32'd0);
        chk("rerst x3", dut.regs[3], 32'd0);
        rst = 1'b1;
        tick();
        chk("rerun x1", dut.regs[1], 32'd5);
        chk("rerun x2", dut.regs[2], 32'd0);
        tick();
        tick();
        chk("rerun x3", dut.regs[3], 32'd2);

        // Writes to x0 are discarded
        clear_imem();
        ld(0, e_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
        ld(1, e_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4));
        do_reset();
        repeat (2) tick();
        chk("x0 x0", dut.regs[0], 32'd0);
        chk("x0 x4", dut.regs[4], 32'd0);

        // Store then load
        clear_imem();
        ld(0, e_i(12'h040, 5'd0, 3'd0, 5'd1, 7'h13));
        ld(1, e_s(12'd8, 5'd1, 5'd0, 3'd2));
        ld(2, e_i(12'd8, 5'd0, 3'd2, 5'd5, 7'h03));
        do_reset();
        repeat (3) tick();
        chk("sw dmem2", dut.dmem[2], 32'h0000_0040);
        chk("lw x5", dut.regs[5], 32'h0000_0040);

        // Taken branch and JAL
        clear_imem();
        ld(0, e_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));
        ld(1, e_b(13'd8, 5'd1, 5'd1, 3'd0));
        ld(2, e_i(12'd9, 5'd0, 3'd0, 5'd2, 7'h13));
        ld(3, e_i(12'd3, 5'd0, 3'd0, 5'd3, 7'h13));
        ld(4, e_j(21'd8, 5'd6));
        do_reset();
        repeat (4) tick();
        chk("br x2", dut.regs[2], 32'd0);
        chk("br x3", dut.regs[3], 32'd3);
        chk("jal x6", dut.regs[6], 32'h0000_0014);
        chk("jal pc", dut.pc, 32'h0000_0018);

        // Shifts and compares on a negative value
        clear_imem();
        ld(0, e_u(20'h80000, 5'd7, 7'h37));
        ld(1, e_i(12'h404, 5'd7, 3'd5, 5'd8, 7'h13));
        ld(2, e_i(12'h004, 5'd7, 3'd5, 5'd9, 7'h13));
        ld(3, e_r(7'h00, 5'd0, 5'd7, 3'd2, 5'd10));
        ld(4, e_r(7'h00, 5'd0, 5'd7, 3'd3, 5'd11));
        do_reset();
        repeat (5) tick();
        chk("srai x8", dut.regs[8], 32'hF800_0000);
        chk("srli x9", dut.regs[9], 32'h0800_0000);
        chk("slt x10", dut.regs[10], 32'd1);
        chk("sltu x11", dut.regs[11], 32'd0);

        // JALR clears bit 0 of the target
        clear_imem();
        ld(0, e_i(12'h011, 5'd0, 3'd0, 5'd1, 7'h13));
        ld(1, e_i(12'd4, 5'd1, 3'd0, 5'd2, 7'h67));
        for (int i = 2; i < 5; i++) ld(i, e_i(12'd1, 5'd0, 3'd0, 5'd3, 7'h13));
        ld(5, e_i(12'd4, 5'd0, 3'd0, 5'd4, 7'h13));
        do_reset();
        repeat (3) tick();
        chk("jalr pc", dut.pc, 32'h0000_0018);
        chk("jalr x2", dut.regs[2], 32'd8);
        chk("jalr x3", dut.regs[3], 32'd0);
        chk("jalr x4", dut.regs[4], 32'd4);

        // Fetch beyond the table behaves as NOP
        clear_imem();
        ld(0, e_i(12'd9, 5'd0, 3'd0, 5'd1, 7'h13));
        ld(1, e_j(21'h7C, 5'd0));
        do_reset();
        repeat (2) tick();
        chk("oob pc0", dut.pc, 32'h0000_0080);
        repeat (3) tick();
        chk("oob pc1", dut.pc, 32'h0000_008C);
        chk("oob x1", dut.regs[1], 32'd9);
        chk("oob x2", dut.regs[2], 32'd0);
        chk("oob dmem0", dut.dmem[0], 32'd0);

        // Random programs against the model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) ld(i, rnd_insn());
            do_reset();
            for (int c = 0; c < 32; c++) begin
                tick();
                iss_step();
                chk($sformatf("rnd%0d c%0d pc", r, c), dut.pc, m_pc);
                for (int i = 0; i < 32; i++) begin
                    chk($sformatf("rnd%0d c%0d x%0d", r, c, i),
                        dut.regs[i], m_regs[i]);
                end
            end
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("rnd%0d dmem%0d", r, i), dut.dmem[i], m_dmem[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
